pulse_meter: RTL and testbench
==============================

PULSE_METER -- requirements
Module: pulse_meter

Interface
REQ-001 Parameter: WIDTH, default 8, bit width of the measurement counters and results.
REQ-002 Parameter: SYNC_STAGES, default 2, number of synchronizer flops on the signal input (minimum 2).
REQ-003 Port: clock  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: enable  input  1  measurement enable; low forces IDLE synchronously.
REQ-006 Port: signal  input  1  pulse train under measurement; asynchronous to clock.
REQ-007 Port: rise  output  1  one-cycle strobe per detected rising edge.
REQ-008 Port: fall  output  1  one-cycle strobe per detected falling edge.
REQ-009 Port: high_width  output  WIDTH  clock cycles the last complete pulse was high.
REQ-010 Port: period  output  WIDTH  clock cycles between the last two rising edges.
REQ-011 Port: width_valid  output  1  one-cycle strobe when high_width updates.
REQ-012 Port: period_valid  output  1  one-cycle strobe when period updates.
REQ-013 Port: overflow  output  1  sticky flag; a counter saturated since reset.

Function
REQ-014 signal SHALL pass through SYNC_STAGES flops, then one delay flop (s, s_d); rise/fall SHALL be registered from s & ~s_d and ~s & s_d: 3 clocks of latency from the first sampling edge at SYNC_STAGES=2.
REQ-015 FSM states SHALL be IDLE, ARMED, HIGH, LOW.
REQ-016 IDLE: counters cleared; move to ARMED when enable=1 and s=0 (a pulse already high at enable is never measured).
REQ-017 ARMED: on detected rise, go to HIGH, hi_cnt=1, per_cnt=1; no period_valid on this first rise.
REQ-018 HIGH: hi_cnt and per_cnt increment each cycle; on detected fall, high_width<=hi_cnt, width_valid=1 for one cycle, go to LOW.
REQ-019 LOW: per_cnt increments; on detected rise, period<=per_cnt, period_valid=1 for one cycle, hi_cnt=1, per_cnt=1, go to HIGH.
REQ-020 Counters SHALL saturate at 2^WIDTH-1, never wrap; reaching saturation SHALL set overflow, which holds until reset.
REQ-021 A one-cycle high pulse after synchronization SHALL yield high_width=1.
REQ-022 enable falling SHALL return FSM to IDLE next clock; high_width/period hold their last values; strobes forced to 0.
REQ-023 rise and fall SHALL never assert in the same cycle; width_valid and period_valid SHALL never assert in the same cycle.
REQ-024 rise/fall strobes SHALL be produced in every state, independent of enable.

Reset
REQ-025 On reset=1, immediately: FSM=IDLE, all synchronizer and delay flops=0, rise=fall=0, width_valid=period_valid=0, high_width=0, period=0, overflow=0, internal counters=0.
REQ-026 Reset asserted mid-pulse SHALL discard the partial measurement; after release the first full pulse is measured per REQ-016.

Structure
REQ-027 FSM state encodings (IDLE=2'd0, ARMED=2'd1, HIGH=2'd2, LOW=2'd3) and the default WIDTH SHALL live in shared package pulse_meter_pkg.
REQ-028 Synchronizer plus edge detect SHALL be one sub-module, edge_detect (ports clock, reset, din, rise, fall, level).

Verification
REQ-029 Reset, enable=1, signal high 5 cycles / low 7 cycles repeated -> width_valid with high_width=5 after first fall; period_valid with period=12 after second rise; overflow=0.
REQ-030 signal=1 at reset release, enable=1 -> no width_valid until signal has gone low and a full new pulse completes.
REQ-031 WIDTH=8, signal high 300 cycles then low -> high_width=255, overflow=1 and stays 1 after further normal pulses.
REQ-032 Single-cycle-high signal aligned to clock -> rise then fall one cycle apart, high_width=1.
REQ-033 Reset asserted 3 cycles into a 10-cycle pulse -> all outputs 0 asynchronously; next full 4-cycle pulse reports high_width=4.
REQ-034 enable dropped during LOW -> no period_valid on next rise; high_width/period retain prior values.

Source files
------------

// File: rtl/pulse_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pulse_meter_pkg
// Description : Shared FSM encodings and default sizing for the pulse meter.
// Revision    : 1.0 - initial release
// ============================================================================
package pulse_meter_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ARMED = 2'd1;
    localparam logic [1:0] HIGH  = 2'd2;
    localparam logic [1:0] LOW   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : edge_detect
// Description : Multi-flop synchronizer, delay flop and registered edge strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall,
    output logic level
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   dly_q, dly_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   w_s;

    assign w_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        dly_d  = w_s;
        rise_d = w_s & ~dly_q;
        fall_d = ~w_s & dly_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise  = rise_q;
    assign fall  = fall_q;
    assign level = w_s;

endmodule
`default_nettype wire

// File: rtl/pulse_meter.sv
`default_nettype none
// ============================================================================
// Module      : pulse_meter
// Description : Measures high width and period of an asynchronous pulse train.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_meter
    import pulse_meter_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             signal,
    output logic             rise,
    output logic             fall,
    output logic [WIDTH-1:0] high_width,
    output logic [WIDTH-1:0] period,
    output logic             width_valid,
    output logic             period_valid,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic                   w_level;
    logic                   w_primed;
    logic [WIDTH-1:0]       w_hi_inc, w_per_inc;

    logic [1:0]             state_q, state_d;
    logic [WIDTH-1:0]       hi_cnt_q, hi_cnt_d;
    logic [WIDTH-1:0]       per_cnt_q, per_cnt_d;
    logic [WIDTH-1:0]       high_width_q, high_width_d;
    logic [WIDTH-1:0]       period_q, period_d;
    logic                   width_valid_q, width_valid_d;
    logic                   period_valid_q, period_valid_d;
    logic                   overflow_q, overflow_d;
    logic [SYNC_STAGES-1:0] fill_q, fill_d;

    edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_detect (
        .clock (clock),
        .reset (reset),
        .din   (signal),
        .rise  (rise),
        .fall  (fall),
        .level (w_level)
    );

    // The synchronizer holds reset zeros for SYNC_STAGES clocks; arming on
    // those would measure a pulse that was already high at reset release.
    assign w_primed  = fill_q[SYNC_STAGES-1];
    assign w_hi_inc  = (hi_cnt_q  == CNT_MAX) ? hi_cnt_q  : hi_cnt_q  + CNT_ONE;
    assign w_per_inc = (per_cnt_q == CNT_MAX) ? per_cnt_q : per_cnt_q + CNT_ONE;

    always_comb begin
        state_d        = state_q;
        hi_cnt_d       = hi_cnt_q;
        per_cnt_d      = per_cnt_q;
        high_width_d   = high_width_q;
        period_d       = period_q;
        width_valid_d  = 1'b0;
        period_valid_d = 1'b0;
        overflow_d     = overflow_q;
        fill_d         = {fill_q[SYNC_STAGES-2:0], 1'b1};

        if (!enable) begin
            state_d   = IDLE;
            hi_cnt_d  = '0;
            per_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    hi_cnt_d  = '0;
                    per_cnt_d = '0;
                    if (w_primed && !w_level) state_d = ARMED;
                end
                ARMED: begin
                    if (rise) begin
                        state_d   = HIGH;
                        hi_cnt_d  = CNT_ONE;
                        per_cnt_d = CNT_ONE;
                    end
                end
                HIGH: begin
                    per_cnt_d = w_per_inc;
                    if (fall) begin
                        high_width_d  = hi_cnt_q;
                        width_valid_d = 1'b1;
                        state_d       = LOW;
                    end else begin
                        hi_cnt_d = w_hi_inc;
                    end
                end
                LOW: begin
                    per_cnt_d = w_per_inc;
                    if (rise) begin
                        period_d       = per_cnt_q;
                        period_valid_d = 1'b1;
                        hi_cnt_d       = CNT_ONE;
                        per_cnt_d      = CNT_ONE;
                        state_d        = HIGH;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if ((hi_cnt_d == CNT_MAX) || (per_cnt_d == CNT_MAX)) overflow_d = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            hi_cnt_q       <= '0;
            per_cnt_q      <= '0;
            high_width_q   <= '0;
            period_q       <= '0;
            width_valid_q  <= 1'b0;
            period_valid_q <= 1'b0;
            overflow_q     <= 1'b0;
            fill_q         <= '0;
        end else begin
            state_q        <= state_d;
            hi_cnt_q       <= hi_cnt_d;
            per_cnt_q      <= per_cnt_d;
            high_width_q   <= high_width_d;
            period_q       <= period_d;
            width_valid_q  <= width_valid_d;
            period_valid_q <= period_valid_d;
            overflow_q     <= overflow_d;
            fill_q         <= fill_d;
        end
    end

    assign high_width   = high_width_q;
    assign period       = period_q;
    assign width_valid  = width_valid_q;
    assign period_valid = period_valid_q;
    assign overflow     = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_meter
// Description : Directed self-checking bench for pulse_meter (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_meter;

    localparam int WIDTH = 8;

    logic             clock = 1'b0;
    logic             reset;
    logic             enable;
    logic             signal;
    logic             rise, fall;
    logic [WIDTH-1:0] high_width, period;
    logic             width_valid, period_valid, overflow;

    int tests  = 0;
    int fails  = 0;
    int cyc    = 0;
    int wv_cnt = 0;
    int pv_cnt = 0;
    int last_hw  = -1;
    int last_per = -1;
    int rise_cyc = 0;
    int fall_cyc = 0;
    int n_wv, n_pv;

    pulse_meter #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .signal       (signal),
        .rise         (rise),
        .fall         (fall),
        .high_width   (high_width),
        .period       (period),
        .width_valid  (width_valid),
        .period_valid (period_valid),
        .overflow     (overflow)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    // Strobe monitor: captures reported values and checks mutual exclusion.
    always @(negedge clock) begin
        if (width_valid) begin
            wv_cnt++;
            last_hw = int'(high_width);
        end
        if (period_valid) begin
            pv_cnt++;
            last_per = int'(period);
        end
        if (rise) rise_cyc = cyc;
        if (fall) fall_cyc = cyc;
        tests++;
        assert (!(rise && fall) && !(width_valid && period_valid)) else begin
            fails++;
            $error("FAIL excl: rise=%0b fall=%0b wv=%0b pv=%0b, required no pair high",
                   rise, fall, width_valid, period_valid);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse(input int hi, input int lo);
        signal = 1'b1;
        cycles(hi);
        signal = 1'b0;
        cycles(lo);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_strobes"}, 32'({rise, fall, width_valid, period_valid, overflow}), 32'd0);
        chk({tag, "_hw"}, 32'(high_width), 32'd0);
        chk({tag, "_per"}, 32'(period), 32'd0);
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        signal = 1'b0;
        #1;
        chk_reset_outputs("reset");
        cycles(2);
        reset = 1'b0;
        cycles(5);

        // First pulse: rise strobe appears on the third sampling edge.
        signal = 1'b1;
        cycles(2);
        chk("rise_latency_early", 32'(rise), 32'd0);
        cycles(1);
        chk("rise_latency", 32'(rise), 32'd1);
        cycles(2);
        signal = 1'b0;
        cycles(7);
        pulse(5, 7);
        pulse(5, 7);
        chk("basic_wv_count", 32'(wv_cnt), 32'd3);
        chk("basic_hw", 32'(last_hw), 32'd5);
        chk("basic_pv_count", 32'(pv_cnt), 32'd2);
        chk("basic_period", 32'(last_per), 32'd12);
        chk("basic_overflow", 32'(overflow), 32'd0);

        // Disable while in LOW: values hold, first rise after re-arm gives no period.
        enable = 1'b0;
        cycles(2);
        chk("dis_hw_hold", 32'(high_width), 32'd5);
        chk("dis_per_hold", 32'(period), 32'd12);
        enable = 1'b1;
        cycles(3);
        n_pv = pv_cnt;
        n_wv = wv_cnt;
        pulse(5, 7);
        chk("rearm_no_pv", 32'(pv_cnt), 32'(n_pv));
        chk("rearm_wv", 32'(wv_cnt), 32'(n_wv + 1));
        chk("rearm_per_hold", 32'(period), 32'd12);

        pulse(3, 6);
        chk("p3_period", 32'(last_per), 32'd12);
        chk("p3_hw", 32'(last_hw), 32'd3);
        pulse(2, 5);
        chk("p2_period", 32'(last_per), 32'd9);
        chk("p2_hw", 32'(last_hw), 32'd2);

        pulse(1, 6);
        chk("single_rise_fall_gap", 32'(fall_cyc - rise_cyc), 32'd1);
        chk("single_hw", 32'(last_hw), 32'd1);
        chk("single_period", 32'(last_per), 32'd7);
        chk("pre_sat_overflow", 32'(overflow), 32'd0);

        pulse(300, 10);
        chk("sat_hw", 32'(last_hw), 32'd255);
        chk("sat_overflow", 32'(overflow), 32'd1);
        pulse(5, 7);
        chk("sat_period", 32'(last_per), 32'd255);
        chk("post_sat_hw", 32'(last_hw), 32'd5);
        chk("overflow_sticky", 32'(overflow), 32'd1);

        // Signal already high at reset release is never measured.
        signal = 1'b1;
        reset  = 1'b1;
        #1;
        chk_reset_outputs("reset_hi");
        cycles(2);
        reset = 1'b0;
        n_wv  = wv_cnt;
        n_pv  = pv_cnt;
        cycles(8);
        chk("hi_release_no_wv", 32'(wv_cnt), 32'(n_wv));
        signal = 1'b0;
        cycles(6);
        pulse(4, 6);
        chk("hi_release_wv", 32'(wv_cnt), 32'(n_wv + 1));
        chk("hi_release_hw", 32'(last_hw), 32'd4);
        chk("hi_release_no_pv", 32'(pv_cnt), 32'(n_pv));

        // Reset three cycles into a ten-cycle pulse.
        signal = 1'b1;
        cycles(3);
        reset = 1'b1;
        #1;
        chk_reset_outputs("mid_reset");
        cycles(2);
        reset = 1'b0;
        n_wv  = wv_cnt;
        n_pv  = pv_cnt;
        cycles(5);
        signal = 1'b0;
        cycles(6);
        pulse(4, 6);
        chk("mid_reset_wv", 32'(wv_cnt), 32'(n_wv + 1));
        chk("mid_reset_hw", 32'(last_hw), 32'd4);
        chk("mid_reset_no_pv", 32'(pv_cnt), 32'(n_pv));
        chk("mid_reset_overflow", 32'(overflow), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
